gpio_in_cond: RTL and testbench

- Input conditioning stage directly upstream of the GPIO Wishbone slave; its o_gpio drives the slave's i_gpio.
- Per pin: synchronises asynchronous pad inputs, debounces them, and detects rising and falling edges.
- Edges accumulate in sticky pending flags, which are combined into a single level interrupt for the core.

---
 rtl/gpio_pkg.sv | 18 +
 rtl/gpio_db_bit.sv | 87 ++++++++
 rtl/gpio_in_cond.sv | 86 ++++++++
 tb/tb_gpio_in_cond.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: default widths, debounce counter width and edge-type encodings.
package gpio_pkg;

  localparam int GPIO_WIDTH = 32;
  localparam int SYNC_DEPTH = 2;
  localparam int DB_CNT_W   = 4;

  // Encodings are kept stable so a future edge-config register block can share them.
  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_e;

  function automatic logic edge_hit(input logic cur, input logic prev, input edge_e kind);
    return (kind == EDGE_RISE) ? (cur & ~prev) : (~cur & prev);
  endfunction

endpackage

// File: rtl/gpio_db_bit.sv
// One pin: synchroniser, optional debounce (GPIO_IN_DEBOUNCE_EN), stable level and edge detect.
module gpio_db_bit
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_DEPTH,
  parameter int DB_COUNT    = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
`ifdef GPIO_IN_DEBOUNCE_EN
  input  logic tick_i,
`endif
  input  logic rise_en_i,
  input  logic fall_en_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("gpio_db_bit: SYNC_STAGES must be >= 2");
  end
  if (DB_COUNT < 1 || DB_COUNT > 15) begin : g_bad_count
    $error("gpio_db_bit: DB_COUNT must be in 1..15");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   stable_q, stable_d;
  logic                   stable_dly_q;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  // Any agreeing cycle restarts the count, so only an unbroken disagreement is accepted.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync == stable_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == DB_CNT_W'(DB_COUNT - 1)) begin
        stable_d = sync;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign stable_d = sync;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
    end else begin
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = edge_hit(stable_q, stable_dly_q, EDGE_RISE) & rise_en_i;
  assign fall_o   = edge_hit(stable_q, stable_dly_q, EDGE_FALL) & fall_en_i;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: per-pin sync/debounce/edge detect, sticky pending flags, level irq.
// Debounce prescaler and counters are built only when GPIO_IN_DEBOUNCE_EN is defined.
module gpio_in_cond
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH,
  parameter int SYNC_STAGES = SYNC_DEPTH,
  parameter int DB_PRESCALE = 1000,
  parameter int DB_COUNT    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_pad,
  input  logic [WIDTH-1:0] i_rise_en,
  input  logic [WIDTH-1:0] i_fall_en,
  input  logic [WIDTH-1:0] i_clr,
  output logic [WIDTH-1:0] o_gpio,
  output logic [WIDTH-1:0] o_pending,
  output logic             o_irq
);

  if (DB_PRESCALE < 2) begin : g_bad_prescale
    $error("gpio_in_cond: DB_PRESCALE must be >= 2");
  end

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             irq_q;

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int PW = $clog2(DB_PRESCALE);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick    = (presc_q == PW'(DB_PRESCALE - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`endif

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    gpio_db_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_COUNT   (DB_COUNT)
    ) u_bit (
      .clk_i    (i_clk),
      .rst_i    (i_rst),
      .pad_i    (i_pad[g]),
`ifdef GPIO_IN_DEBOUNCE_EN
      .tick_i   (tick),
`endif
      .rise_en_i(i_rise_en[g]),
      .fall_en_i(i_fall_en[g]),
      .stable_o (stable[g]),
      .rise_o   (rise[g]),
      .fall_o   (fall[g])
    );
  end

  // Set has priority over a coincident clear so no edge is silently dropped.
  assign pending_d = (pending_q & ~i_clr) | rise | fall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      irq_q     <= |pending_q;
    end
  end

  assign o_gpio    = stable;
  assign o_pending = pending_q;
  assign o_irq     = irq_q;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Self-checking bench for gpio_in_cond (WIDTH=8, DB_PRESCALE=4, DB_COUNT=3); adapts to GPIO_IN_DEBOUNCE_EN.
module tb_gpio_in_cond;

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] pad, rise_en, fall_en, clr;
  logic [7:0] gpio, pending;
  logic       irq;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  gpio_in_cond #(
    .WIDTH      (8),
    .SYNC_STAGES(2),
    .DB_PRESCALE(4),
    .DB_COUNT   (3)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_pad    (pad),
    .i_rise_en(rise_en),
    .i_fall_en(fall_en),
    .i_clr    (clr),
    .o_gpio   (gpio),
    .o_pending(pending),
    .o_irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) at negedges until (o_gpio & mask) == val; n = negedges waited.
  task automatic wait_gpio(input logic [7:0] mask, input logic [7:0] val, output int n);
    n = 0;
    while (((gpio & mask) !== val) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((gpio & mask) !== val) begin
      failures++;
      $display("FAIL wait_gpio timeout: o_gpio=%h mask=%h required=%h", gpio, mask, val);
    end
  endtask

  task automatic settle_clear();
    repeat (40) @(negedge clk);
    clr = 8'hFF;
    @(negedge clk);
    clr = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; pad = 8'h00; rise_en = 8'h00; fall_en = 8'h00; clr = 8'h00;
    repeat (3) @(negedge clk);
    checks += 3;
    if (gpio !== 8'h00)    begin failures++; $display("FAIL reset_gpio: got %h want 00", gpio); end
    if (pending !== 8'h00) begin failures++; $display("FAIL reset_pending: got %h want 00", pending); end
    if (irq !== 1'b0)      begin failures++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst = 1'b0;
    pad = 8'hFF; rise_en = 8'hFF;
    wait_gpio(8'hFF, 8'hFF, n);
    exp_q.push_back(8'hFF);
    @(negedge clk);
    checks++;
    if (pending !== 8'(exp_q.pop_front())) begin
      failures++; $display("FAIL pre_reset_pending: got %h want ff", pending);
    end
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (gpio !== 8'h00)    begin failures++; $display("FAIL async_rst_gpio: got %h want 00", gpio); end
    if (pending !== 8'h00) begin failures++; $display("FAIL async_rst_pending: got %h want 00", pending); end
    if (irq !== 1'b0)      begin failures++; $display("FAIL async_rst_irq: got %b want 0", irq); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < (DB ? 10 : 2); i++) begin
      @(negedge clk);
      checks++;
      if (gpio !== 8'h00) begin
        failures++; $display("FAIL post_rst_hold cycle %0d: got %h want 00", i + 1, gpio);
      end
    end
    pad = 8'h00; rise_en = 8'h00;
    settle_clear();
  endtask

  task automatic test_glitch();
    int hi_cycles;
    exp_q.push_back(DB ? 0 : 1);
    pad[1] = 1'b1;
    repeat (DB ? 3 : 1) @(negedge clk);
    pad[1] = 1'b0;
    hi_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gpio[1] === 1'b1) hi_cycles++;
      checks++;
      if (pending !== 8'h00) begin
        failures++; $display("FAIL glitch_pending cycle %0d: got %h want 00", i, pending);
      end
    end
    checks++;
    if (hi_cycles !== exp_q.pop_front()) begin
      failures++; $display("FAIL glitch_gpio_high_cycles: got %0d want %0d", hi_cycles, DB ? 0 : 1);
    end
  endtask

  task automatic test_clean_rise();
    int n;
    rise_en = 8'h01;
    pad[0]  = 1'b1;
    @(negedge clk);
    wait_gpio(8'h01, 8'h01, n);
    n++;
    checks++;
    if (DB ? (n < 10 || n > 15) : (n != 3)) begin
      failures++; $display("FAIL rise_latency: got %0d cycles want %s", n, DB ? "10..15" : "3");
    end
    checks++;
    if (pending !== 8'h00) begin failures++; $display("FAIL rise_pending_early: got %h want 00", pending); end
    exp_q.push_back(8'h01);
    @(negedge clk);
    checks += 2;
    if (pending !== 8'(exp_q.pop_front())) begin failures++; $display("FAIL rise_pending: got %h want 01", pending); end
    if (irq !== 1'b0) begin failures++; $display("FAIL rise_irq_early: got %b want 0", irq); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL rise_irq: got %b want 1", irq); end
  endtask

  task automatic test_clear_vs_set();
    int n;
    fall_en = 8'h01;
    pad[0]  = 1'b0;
    n = 0;
    while (gpio[0] !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (gpio[0] !== 1'b0) begin failures++; $display("FAIL fall_timeout: o_gpio=%h want bit0=0", gpio); end
    clr = 8'h01;
    exp_q.push_back(8'h01);
    @(negedge clk);
    clr = 8'h00;
    checks += 2;
    if (pending !== 8'(exp_q.pop_front())) begin failures++; $display("FAIL set_wins_pending: got %h want 01", pending); end
    if (irq !== 1'b1) begin failures++; $display("FAIL set_wins_irq: got %b want 1", irq); end
    repeat (3) @(negedge clk);
    clr = 8'h01;
    @(negedge clk);
    clr = 8'h00;
    checks += 2;
    if (pending !== 8'h00) begin failures++; $display("FAIL clear_pending: got %h want 00", pending); end
    if (irq !== 1'b1) begin failures++; $display("FAIL clear_irq_lag: got %b want 1", irq); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL clear_irq: got %b want 0", irq); end
  endtask

  task automatic test_disabled_edge();
    int n;
    rise_en = 8'h00; fall_en = 8'h00;
    pad[2]  = 1'b1;
    exp_q.push_back(8'h04);
    wait_gpio(8'h04, 8'h04, n);
    @(negedge clk);
    rise_en = 8'hFF;
    repeat (5) @(negedge clk);
    checks += 3;
    if (gpio !== 8'(exp_q.pop_front())) begin failures++; $display("FAIL disabled_gpio: got %h want 04", gpio); end
    if (pending !== 8'h00) begin failures++; $display("FAIL disabled_pending: got %h want 00", pending); end
    if (irq !== 1'b0) begin failures++; $display("FAIL disabled_irq: got %b want 0", irq); end
    rise_en = 8'h00;
  endtask

  task automatic test_multi_pin();
    int n;
    rise_en = 8'h30; fall_en = 8'h00;
    pad = 8'h74;
    exp_q.push_back(8'h30);
    wait_gpio(8'hFF, 8'h74, n);
    @(negedge clk);
    checks++;
    if (pending !== 8'(exp_q.pop_front())) begin failures++; $display("FAIL multi_rise_pending: got %h want 30", pending); end
    fall_en = 8'h40;
    pad = 8'h04;
    exp_q.push_back(8'h70);
    wait_gpio(8'hFF, 8'h04, n);
    @(negedge clk);
    checks++;
    if (pending !== 8'(exp_q.pop_front())) begin failures++; $display("FAIL multi_fall_pending: got %h want 70", pending); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL multi_irq: got %b want 1", irq); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clean_rise();
    test_clear_vs_set();
    test_disabled_edge();
    test_multi_pin();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
